// File: rtl/shifter_arbiter2_pkg.sv
// Shared constants for the two-requester shift-unit arbiter.
package shifter_arbiter2_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Requester identifiers (also the operand-mux select value)
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int CNT_W = 8;

  // One-hot vector for a requester id
  function automatic logic [1:0] onehot2(input logic id);
    return (id == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shifter_arbiter2_rr_pick2.sv
// Combinational two-way round-robin winner selection.
module shifter_arbiter2_rr_pick2
  import shifter_arbiter2_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic       o_valid,
  output logic       o_winner
);

  // A lone requester wins; on contention the priority holder wins
  always_comb begin
    o_valid  = |i_req;
    o_winner = REQ0;
    case (i_req)
      2'b10:   o_winner = REQ1;
      2'b11:   o_winner = i_prio;
      default: o_winner = REQ0;
    endcase
  end

endmodule

// File: rtl/shifter_arbiter2.sv
// Round-robin arbiter and latency sequencer for one shared shift unit.
//
// state  | meaning
// S_IDLE | no grant; waiting for a request
// S_BUSY | grant held, counting down the unit latency
// S_DONE | result captured, done pulse high for one cycle
module shifter_arbiter2
  import shifter_arbiter2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req,
  output logic [1:0]            o_gnt,
  output logic                  o_mux_sel,
  output logic                  o_unit_start,
  input  logic [DATA_WIDTH-1:0] i_unit_result,
  output logic [1:0]            o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("shifter_arbiter2: LATENCY must be within 1..255");
  end

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_gnt;
  logic                  r_mux_sel;
  logic [1:0]            r_done;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_prio;

  logic                  w_any;
  logic                  w_winner;

  shifter_arbiter2_rr_pick2 u_pick (
    .i_req    (i_req),
    .i_prio   (r_prio),
    .o_valid  (w_any),
    .o_winner (w_winner)
  );

  // Grant, count down the unit latency, capture the result, pulse done.
  // r_mux_sel doubles as the id of the requester being served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_mux_sel <= REQ0;
      r_done    <= '0;
      r_result  <= '0;
      r_prio    <= REQ0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= onehot2(w_winner);
            r_mux_sel <= w_winner;
            r_cnt     <= LAT_CNT;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result <= i_unit_result;
            r_gnt    <= '0;
            r_done   <= onehot2(r_mux_sel);
            r_prio   <= ~r_mux_sel;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Start pulse marks the first BUSY cycle, when the mux output is valid
  always_comb begin
    o_unit_start = (r_state == S_BUSY) && (r_cnt == LAT_CNT);
  end

  assign o_gnt     = r_gnt;
  assign o_mux_sel = r_mux_sel;
  assign o_done    = r_done;
  assign o_result  = r_result;

endmodule

// File: tb/tb_shifter_arbiter2.sv
// Directed bench for shifter_arbiter2 at LATENCY 1, 3, 4 and 2.
module tb_shifter_arbiter2;

  logic clk;
  logic rst_n;
  logic rst_c;

  logic [1:0] req_a, gnt_a, done_a;
  logic       sel_a, st_a;
  logic [7:0] ur_a, res_a;

  logic [1:0] req_b, gnt_b, done_b;
  logic       sel_b, st_b;
  logic [7:0] ur_b, res_b;

  logic [1:0] req_c, gnt_c, done_c;
  logic       sel_c, st_c;
  logic [7:0] ur_c, res_c;

  logic [1:0] req_d, gnt_d, done_d;
  logic       sel_d, st_d;
  logic [7:0] ur_d, res_d;

  int n_chk;
  int n_fail;

  shifter_arbiter2 #(.DATA_WIDTH(8), .LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .o_gnt(gnt_a),
    .o_mux_sel(sel_a), .o_unit_start(st_a), .i_unit_result(ur_a),
    .o_done(done_a), .o_result(res_a));

  shifter_arbiter2 #(.DATA_WIDTH(8), .LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .o_gnt(gnt_b),
    .o_mux_sel(sel_b), .o_unit_start(st_b), .i_unit_result(ur_b),
    .o_done(done_b), .o_result(res_b));

  shifter_arbiter2 #(.DATA_WIDTH(8), .LATENCY(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_c), .i_req(req_c), .o_gnt(gnt_c),
    .o_mux_sel(sel_c), .o_unit_start(st_c), .i_unit_result(ur_c),
    .o_done(done_c), .o_result(res_c));

  shifter_arbiter2 #(.DATA_WIDTH(8), .LATENCY(2)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_d), .o_gnt(gnt_d),
    .o_mux_sel(sel_d), .o_unit_start(st_d), .i_unit_result(ur_d),
    .o_done(done_d), .o_result(res_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] vals [4];
    logic [1:0] oh;
    logic       w;
    n_chk  = 0;
    n_fail = 0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

    // Reset held with both requests high
    rst_n = 1'b0; rst_c = 1'b0;
    req_a = 2'b11; req_b = 2'b11; req_c = 2'b11; req_d = 2'b11;
    ur_a = 8'hFF; ur_b = 8'hFF; ur_c = 8'hFF; ur_d = 8'hFF;
    tick(); tick(); tick();
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_sel", 32'(sel_a), 32'h0);
    chk("rst_result", 32'(res_a), 32'h0);
    chk("rst_start", 32'(st_a), 32'h0);
    chk("rst_gnt_c", 32'(gnt_c), 32'h0);
    req_a = 2'b00; req_b = 2'b00; req_c = 2'b00; req_d = 2'b00;
    rst_n = 1'b1; rst_c = 1'b1;
    tick();
    chk("idle_gnt", 32'(gnt_a), 32'h0);

    // LATENCY=1 single request from requester 1
    req_a = 2'b10; ur_a = 8'hA5;
    tick();
    chk("l1_gnt", 32'(gnt_a), 32'h2);
    chk("l1_sel", 32'(sel_a), 32'h1);
    chk("l1_start", 32'(st_a), 32'h1);
    chk("l1_done_early", 32'(done_a), 32'h0);
    tick();
    chk("l1_done", 32'(done_a), 32'h2);
    chk("l1_result", 32'(res_a), 32'hA5);
    chk("l1_gnt_off", 32'(gnt_a), 32'h0);
    chk("l1_start_off", 32'(st_a), 32'h0);
    req_a = 2'b00; ur_a = 8'h00;
    tick();
    chk("l1_done_clr", 32'(done_a), 32'h0);
    chk("l1_result_hold", 32'(res_a), 32'hA5);
    chk("l1_sel_hold", 32'(sel_a), 32'h1);

    // LATENCY=3 contention: grants alternate starting with requester 0
    req_b = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w  = k[0];
      oh = w ? 2'b10 : 2'b01;
      ur_b = vals[k];
      tick();
      chk("c3_gnt", 32'(gnt_b), 32'(oh));
      chk("c3_sel", 32'(sel_b), 32'(w));
      chk("c3_start", 32'(st_b), 32'h1);
      req_b = 2'b11;
      tick();
      chk("c3_start_once", 32'(st_b), 32'h0);
      tick();
      chk("c3_no_done", 32'(done_b), 32'h0);
      tick();
      chk("c3_done", 32'(done_b), 32'(oh));
      chk("c3_result", 32'(res_b), 32'(vals[k]));
      tick();
      chk("c3_done_clr", 32'(done_b), 32'h0);
      chk("c3_start_idle", 32'(st_b), 32'h0);
      if (k == 3) req_b = 2'b00;
      else        req_b = w ? 2'b01 : 2'b10;
    end
    tick();
    chk("c3_idle", 32'(gnt_b), 32'h0);

    // Re-grant without contention: requester 0 served, then served again
    req_b = 2'b01; ur_b = 8'h5A;
    tick();
    chk("rg_gnt1", 32'(gnt_b), 32'h1);
    tick(); tick(); tick();
    chk("rg_done1", 32'(done_b), 32'h1);
    chk("rg_res1", 32'(res_b), 32'h5A);
    ur_b = 8'h6B;
    tick();
    chk("rg_idle", 32'(gnt_b), 32'h0);
    tick();
    chk("rg_gnt2", 32'(gnt_b), 32'h1);
    chk("rg_start2", 32'(st_b), 32'h1);
    tick(); tick(); tick();
    chk("rg_done2", 32'(done_b), 32'h1);
    chk("rg_res2", 32'(res_b), 32'h6B);
    req_b = 2'b00;
    tick();

    // LATENCY=4: serve requester 0 so priority moves to requester 1
    req_c = 2'b01; ur_c = 8'h3C;
    tick();
    chk("r4_gnt0", 32'(gnt_c), 32'h1);
    tick(); tick(); tick(); tick();
    chk("r4_done0", 32'(done_c), 32'h1);
    chk("r4_res0", 32'(res_c), 32'h3C);
    req_c = 2'b00;
    tick();
    req_c = 2'b11;
    tick();
    chk("r4_prio_gnt", 32'(gnt_c), 32'h2);
    tick();
    // second BUSY cycle: asynchronous reset aborts the transaction
    rst_c = 1'b0;
    #1;
    chk("r4_abort_gnt", 32'(gnt_c), 32'h0);
    chk("r4_abort_sel", 32'(sel_c), 32'h0);
    chk("r4_abort_start", 32'(st_c), 32'h0);
    tick();
    chk("r4_abort_done", 32'(done_c), 32'h0);
    rst_c = 1'b1;
    tick();
    chk("r4_prio_reset", 32'(gnt_c), 32'h1);
    tick(); tick(); tick();
    chk("r4_no_done", 32'(done_c), 32'h0);
    ur_c = 8'h81;
    tick();
    chk("r4_done", 32'(done_c), 32'h1);
    chk("r4_res", 32'(res_c), 32'h81);
    req_c = 2'b00;
    tick();

    // LATENCY=2 protocol violation: req dropped during BUSY
    req_d = 2'b01; ur_d = 8'h77;
    tick();
    chk("pv_gnt", 32'(gnt_d), 32'h1);
    req_d = 2'b00; ur_d = 8'h99;
    tick();
    chk("pv_gnt_hold", 32'(gnt_d), 32'h1);
    chk("pv_no_done", 32'(done_d), 32'h0);
    ur_d = 8'hC3;
    tick();
    chk("pv_done", 32'(done_d), 32'h1);
    chk("pv_res", 32'(res_d), 32'hC3);
    ur_d = 8'h00;
    tick();
    chk("pv_done_clr", 32'(done_d), 32'h0);
    chk("pv_res_hold", 32'(res_d), 32'hC3);
    tick();
    chk("pv_no_regrant", 32'(gnt_d), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
